// File: rtl/hs_arb_if.sv
// ---------------------------------------------------------------------------
// hs_arb_if
// Bundle of all handshake and payload signals around hs_rr_arbiter.
//   master : the arbiter's view (drives ack_out, rx_req, rx_data, status)
//   slave  : the surrounding senders/receiver (drive req_in, data_in, rx_ack)
// Signals:
//   req_in      [NUM_REQ]          per-sender req, may be asynchronous
//   data_in     [NUM_REQ*DATA_W]   sender k payload at [k*DATA_W +: DATA_W]
//   ack_out     [NUM_REQ]          per-sender ack
//   rx_req      [1]                req to the receiver
//   rx_ack      [1]                ack from the receiver (clk1 domain)
//   rx_data     [DATA_W]           payload to the receiver
//   grant_id    [clog2(NUM_REQ)]   current / last granted sender
//   busy        [1]                arbiter not idle
//   timeout_err [1]                sticky receiver timeout flag
// ---------------------------------------------------------------------------
interface hs_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_in;
   logic [NUM_REQ*DATA_W-1:0] data_in;
   logic [NUM_REQ-1:0]        ack_out;
   logic                      rx_req;
   logic                      rx_ack;
   logic [DATA_W-1:0]         rx_data;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;
   logic                      timeout_err;

   modport master (
      input  req_in, data_in, rx_ack,
      output ack_out, rx_req, rx_data, grant_id, busy, timeout_err
   );

   modport slave (
      output req_in, data_in, rx_ack,
      input  ack_out, rx_req, rx_data, grant_id, busy, timeout_err
   );
endinterface

// File: rtl/hs_rr_arbiter.sv
// ---------------------------------------------------------------------------
// hs_rr_arbiter
// Round-robin arbiter sharing one 4-phase req/ack receiver port among
// NUM_REQ 4-phase senders. Each req_in bit is synchronised into clk1, one
// transfer is forwarded at a time, and the receiver's ack is routed back
// to the granted sender.
//
// Ports:
//   clk1  : arbiter / receiver clock
//   rst   : asynchronous, active-high reset
//   bus   : hs_arb_if.master (req_in, data_in, ack_out, rx_req, rx_ack,
//           rx_data, grant_id, busy, timeout_err)
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   : FWD gives up after TIMEOUT_CYCLES cycles without rx_ack,
//               acks the sender (payload dropped) and sets sticky timeout_err.
//   undefined : FWD waits indefinitely, timeout_err is constant 0.
// ---------------------------------------------------------------------------
module hs_rr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic      clk1,
   input logic      rst,
   hs_arb_if.master bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_REQ-1:0]  req_s;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                rx_req_q, rx_req_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [DATA_W-1:0]   slice [NUM_REQ];
   logic                found;
   logic [ID_W-1:0]     pick;
   logic [ID_W-1:0]     cand;
   int                  idx;
   logic                timeout_hit;

   // Per-sender payload view of the flat data bus.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign slice[k] = bus.data_in[k*DATA_W +: DATA_W];
   end

   // Synchroniser chain for every req_in bit.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bus.req_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // Round-robin search: first eligible sender strictly after ptr_q,
   // wrapping at NUM_REQ. The pointer itself is visited last, so the
   // previous winner has the lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = ID_W'(idx);
         if (!found && req_s[cand] && !ack_q[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;

   // Counter is zero whenever not in FWD, so it starts at 0 on FWD entry.
   always_comb begin
      cnt_d  = '0;
      terr_d = terr_q;
      if (state_q == FWD) begin
         cnt_d = cnt_q + 1'b1;
         if (timeout_hit && !bus.rx_ack) terr_d = 1'b1;
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end

   assign timeout_hit     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.timeout_err = terr_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ack_q     <= '0;
         rx_req_q  <= 1'b0;
         rx_data_q <= '0;
         grant_q   <= '0;
         ptr_q     <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         rx_req_q  <= rx_req_d;
         rx_data_q <= rx_data_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
      end
   end

   // Next-state logic. A stale rx_ack blocks a new grant so the receiver
   // always sees a clean 4-phase cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (found && !bus.rx_ack) state_d = FWD;
         end
         FWD: begin
            if (bus.rx_ack || timeout_hit) state_d = RELEASE;
         end
         RELEASE: begin
            if (!req_s[grant_q] && !bus.rx_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      ack_d     = ack_q;
      rx_req_d  = rx_req_q;
      rx_data_d = rx_data_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found && !bus.rx_ack) begin
               rx_data_d = slice[pick];
               grant_d   = pick;
               rx_req_d  = 1'b1;
            end
         end
         FWD: begin
            // rx_req falls on the same edge ack rises, so the two never overlap.
            if (bus.rx_ack || timeout_hit) begin
               rx_req_d       = 1'b0;
               ack_d          = '0;
               ack_d[grant_q] = 1'b1;
            end
         end
         RELEASE: begin
            if (!req_s[grant_q] && !bus.rx_ack) begin
               ack_d = '0;
               ptr_d = grant_q;
            end
         end
         default: begin
            ack_d    = '0;
            rx_req_d = 1'b0;
         end
      endcase
   end

   assign bus.ack_out  = ack_q;
   assign bus.rx_req   = rx_req_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hs_rr_arbiter
// Directed bench for hs_rr_arbiter (NUM_REQ=4, DATA_W=8, SYNC_STAGES=2,
// TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the falling
// edge of clk1; the arbiter acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_hs_rr_arbiter;
   logic clk1;
   logic rst;
   int   n_tests;
   int   n_fail;

   hs_arb_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

   hs_rr_arbiter #(
      .NUM_REQ       (4),
      .DATA_W        (8),
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk1(clk1),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time exceeded, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.req_in  = '0;
      bus.rx_ack  = 1'b0;
      bus.data_in = '0;
      repeat (2) @(negedge clk1);
      chk("rst_ack_out", bus.ack_out, 0);
      chk("rst_rx_req", bus.rx_req, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      rst = 1'b0;
      @(negedge clk1);
   endtask

   // Wait for rx_req, check the grant, ack it, let the sender drop req,
   // wait for ack_out to clear; optionally the sender re-requests.
   task automatic xfer(input int id, input logic [7:0] d, input bit rereq);
      int n;
      n = 0;
      while (bus.rx_req !== 1'b1 && n < 40) begin
         @(negedge clk1);
         n++;
      end
      chk("rx_req_up", bus.rx_req, 1);
      chk("grant_id", bus.grant_id, id);
      chk("rx_data", bus.rx_data, d);
      chk("ack_while_req", bus.ack_out, 0);
      bus.rx_ack = 1'b1;
      @(negedge clk1);
      chk("ack_set", bus.ack_out, 32'(1) << id);
      chk("rx_req_down", bus.rx_req, 0);
      bus.rx_ack     = 1'b0;
      bus.req_in[id] = 1'b0;
      n = 0;
      while (bus.ack_out !== 4'b0000 && n < 40) begin
         @(negedge clk1);
         n++;
      end
      chk("ack_clear", bus.ack_out, 0);
      if (rereq) bus.req_in[id] = 1'b1;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.req_in  = '0;
      bus.rx_ack  = 1'b0;
      bus.data_in = '0;
      @(negedge clk1);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      do_reset();

      // Single request on sender 2, exact cycle timing.
      bus.data_in   = {8'h00, 8'hA5, 8'h00, 8'h00};
      bus.req_in[2] = 1'b1;
      @(negedge clk1);
      @(negedge clk1);
      chk("single_rx_req_early", bus.rx_req, 0);
      @(negedge clk1);
      chk("single_rx_req_3cyc", bus.rx_req, 1);
      chk("single_rx_data", bus.rx_data, 8'hA5);
      chk("single_grant", bus.grant_id, 2);
      chk("single_busy", bus.busy, 1);
      bus.rx_ack = 1'b1;
      @(negedge clk1);
      chk("single_ack_rise", bus.ack_out, 4'b0100);
      chk("single_rx_req_fall", bus.rx_req, 0);
      bus.rx_ack    = 1'b0;
      bus.req_in[2] = 1'b0;
      @(negedge clk1);
      @(negedge clk1);
      chk("single_ack_hold", bus.ack_out, 4'b0100);
      @(negedge clk1);
      chk("single_ack_fall", bus.ack_out, 0);
      chk("single_idle", bus.busy, 0);

      // All four request at once, each re-requests after its ack.
      do_reset();
      bus.data_in = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.req_in  = 4'b1111;
      xfer(0, 8'h10, 1'b1);
      xfer(1, 8'h11, 1'b1);
      xfer(2, 8'h12, 1'b1);
      xfer(3, 8'h13, 1'b1);
      xfer(0, 8'h10, 1'b1);

      // Fairness between continuously requesting senders 1 and 3.
      do_reset();
      bus.data_in = {8'h23, 8'h00, 8'h21, 8'h00};
      bus.req_in  = 4'b1010;
      xfer(1, 8'h21, 1'b1);
      xfer(3, 8'h23, 1'b1);
      xfer(1, 8'h21, 1'b1);
      xfer(3, 8'h23, 1'b1);

      // Reset in the middle of a transfer restores the pointer.
      do_reset();
      bus.data_in   = {8'h33, 8'h00, 8'h31, 8'h30};
      bus.req_in[0] = 1'b1;
      xfer(0, 8'h30, 1'b0);
      bus.req_in[3] = 1'b1;
      repeat (4) @(negedge clk1);
      chk("mid_pre_rx_req", bus.rx_req, 1);
      chk("mid_pre_grant", bus.grant_id, 3);
      rst = 1'b1;
      #1;
      chk("mid_rx_req", bus.rx_req, 0);
      chk("mid_ack_out", bus.ack_out, 0);
      chk("mid_busy", bus.busy, 0);
      @(negedge clk1);
      rst        = 1'b0;
      bus.req_in = 4'b1011;
      xfer(0, 8'h30, 1'b0);

      // Stale rx_ack while idle holds off the next grant.
      do_reset();
      bus.data_in   = {8'h00, 8'h00, 8'h00, 8'h5C};
      bus.rx_ack    = 1'b1;
      bus.req_in[0] = 1'b1;
      repeat (6) @(negedge clk1);
      chk("stale_rx_req_held", bus.rx_req, 0);
      chk("stale_busy", bus.busy, 0);
      bus.rx_ack = 1'b0;
      @(negedge clk1);
      chk("stale_rx_req_rise", bus.rx_req, 1);
      xfer(0, 8'h5C, 1'b0);

      // Receiver never acks.
      do_reset();
      bus.data_in   = {8'h00, 8'h00, 8'h5A, 8'h00};
      bus.req_in[1] = 1'b1;
      begin
         int n;
         n = 0;
         while (bus.rx_req !== 1'b1 && n < 40) begin
            @(negedge clk1);
            n++;
         end
         chk("to_rx_req_up", bus.rx_req, 1);
      end
`ifdef ARB_TIMEOUT_EN
      repeat (7) @(negedge clk1);
      chk("to_rx_req_still", bus.rx_req, 1);
      chk("to_err_early", bus.timeout_err, 0);
      @(negedge clk1);
      chk("to_rx_req_drop", bus.rx_req, 0);
      chk("to_ack_out", bus.ack_out, 4'b0010);
      chk("to_err_set", bus.timeout_err, 1);
      bus.req_in[1] = 1'b0;
      repeat (5) @(negedge clk1);
      chk("to_ack_clear", bus.ack_out, 0);
      chk("to_err_sticky", bus.timeout_err, 1);
      do_reset();
      chk("to_err_cleared", bus.timeout_err, 0);
`else
      repeat (20) @(negedge clk1);
      chk("wait_rx_req_held", bus.rx_req, 1);
      chk("wait_no_ack", bus.ack_out, 0);
      chk("wait_err_zero", bus.timeout_err, 0);
      xfer(1, 8'h5A, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream 4-phase req/ack receiver port among NUM_REQ upstream 4-phase senders.
- Sits between multiple 8-bit sender handshake blocks and a single receiver in the clk1 domain.
- Synchronises each incoming req into clk1, serialises transfers, and routes the receiver's ack back to the granted sender.

Parameters:
- NUM_REQ, 4, number of upstream requesters (2..8).
- DATA_W, 8, payload width per requester.
- SYNC_STAGES, 2, flip-flop stages on each req_in bit (minimum 2).
- TIMEOUT_CYCLES, 64, receiver ack timeout in clk1 cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk1  in  1  arbiter and receiver clock.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  NUM_REQ  per-requester req. May be asynchronous to clk1.
- data_in  in  NUM_REQ*DATA_W  requester k occupies bits [k*DATA_W +: DATA_W]. Stable while req_in[k]=1.
- ack_out  out  NUM_REQ  per-requester ack. Registered.
- rx_req  out  1  req to the receiver. Registered.
- rx_ack  in  1  ack from the receiver (clk1 domain, no synchroniser).
- rx_data  out  DATA_W  payload to the receiver. Registered.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky timeout flag. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous) drives:
  - ack_out=0, rx_req=0, rx_data=0, grant_id=0, busy=0, timeout_err=0.
  - Synchroniser flops=0, state=IDLE.
  - Priority pointer=NUM_REQ-1, so requester 0 has first priority.
- req_s[k] is req_in[k] after SYNC_STAGES flops. data_in is sampled directly; it is safe because req is held stable.
- FSM states:
  - IDLE: if any req_s[k]=1 and ack_out[k]=0, pick the first such k searching upward from pointer+1, wrapping modulo NUM_REQ. On that edge: rx_data<=data_in slice k, grant_id<=k, rx_req<=1, go to FWD. If no request, stay in IDLE.
  - FWD: hold rx_req=1 and rx_data. When rx_ack=1: rx_req<=0, ack_out[grant_id]<=1, go to RELEASE.
  - RELEASE: hold ack_out[grant_id]=1 until req_s[grant_id]=0 AND rx_ack=0. Then ack_out<=0, pointer<=grant_id, go to IDLE.
- At most one ack_out bit is high at any time. ack_out is never high while rx_req=1.
- Latency, req_in edge to rx_req rise: SYNC_STAGES+1 clk1 cycles when the arbiter is IDLE.
- Throughput: one transfer per handshake. The minimum is 4 cycles plus the synchroniser delays.
- Simultaneous requests: round-robin order. The last winner gets lowest priority on the next arbitration.
- Wrap-around: the search past NUM_REQ-1 continues at 0.
- Requests arriving during FWD/RELEASE are not lost. They are evaluated in the next IDLE.
- A requester that drops req before being granted is simply not granted; no error.
- rx_ack=1 while in IDLE is ignored. rx_req is not raised until rx_ack=0.
- rst mid-transfer aborts immediately to reset values. The receiver releases ack on its own when rx_req drops.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to FWD and increments every cycle in FWD.
  - On reaching TIMEOUT_CYCLES-1 with rx_ack still 0: rx_req<=0, ack_out[grant_id]<=1 (payload dropped), timeout_err<=1 (sticky until rst), go to RELEASE.
- Not defined: no counter; FWD waits indefinitely; timeout_err is constant 0.

Test Plan:
- Single request: raise req_in[2] with data 8'hA5, receiver acks one cycle after rx_req. Required: rx_data=8'hA5, grant_id=2, rx_req rises 3 cycles after req_in. ack_out[2] rises the cycle after rx_ack and falls after req_in[2] drops.
- Simultaneous requests: req_in=4'b1111 after reset with data 8'h10/11/12/13, each requester dropping req on ack and re-requesting. Required: grant order 0,1,2,3,0 and rx_data sequence 10,11,12,13,10.
- Fairness: requesters 1 and 3 held continuously. Required: grants alternate 1,3,1,3, with no requester granted twice in a row while the other waits.
- Mid-transfer reset: assert rst while in FWD with rx_req=1. Required: same cycle rx_req=0, ack_out=0, busy=0. After release, requester 0 has priority.
- Timeout with ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: rx_ack held 0. Required: rx_req drops after 8 cycles in FWD, ack_out[grant_id]=1, timeout_err=1 and stays 1 until rst.
- Stale ack: rx_ack=1 while IDLE and req_in[0]=1. Required: rx_req stays 0 until rx_ack=0, then rises.
